uart_rx_queue: RTL and testbench
================================

// Module: uart_rx_queue
// PURPOSE
//  UART receive path toward the USB core. Oversamples the selected COM rx line and
//  frames 8N1 bytes (start, 8 data LSB-first, stop). Pushes good bytes into a
//  32-deep FIFO that the USB side drains with a first-word-fall-through pop handshake.
//  Counterpart of the USB->UART transmit queue; sits between the COM pins and the USB IN builder.
// PARAMETERS
//  CLKS_PER_BIT  16  uart_clk cycles per bit; even, >=4
//  FIFO_AW       5   log2 FIFO depth (32 entries)
// PORTS
//  uart_clk      in   1          single clock for all logic
//  uart_rst_n    in   1          synchronous reset, active low
//  uart_rx_com1  in   1          COM1 rx line, async, idle high
//  uart_rx_com2  in   1          COM2 rx line, async, idle high
//  com_sel       in   1          0=COM1, 1=COM2; treated as quasi-static
//  rx_rd         in   1          pop head byte (ignored when rx_empty)
//  ovf_clr       in   1          clears sticky rx_overflow
//  rx_data       out  8          FIFO head byte; 8'h00 when rx_empty
//  rx_empty      out  1          FIFO empty
//  rx_full       out  1          FIFO full
//  rx_count      out  FIFO_AW+1  bytes held, 0..32
//  rx_busy       out  1          framer not in IDLE
//  rx_frame_err  out  1          1-cycle pulse: stop bit sampled low
//  rx_overflow   out  1          sticky: byte dropped because FIFO full
// BEHAVIOUR
//  Reset (uart_rst_n=0 at edge): FSM->IDLE; FIFO pointers and count cleared.
//   rx_empty=1, rx_full=0, rx_count=0, rx_data=0, rx_busy=0, rx_frame_err=0, rx_overflow=0.
//   Reset mid-frame discards the partial byte; FIFO contents are lost.
//  Input: mux by com_sel, then 2-flop synchronizer (reset to 1). All decisions use the sync output.
//  FSM: IDLE, START, DATA, STOP, WAIT_IDLE; bit counter 0..CLKS_PER_BIT-1; 3-bit index.
//   IDLE: sync line 0 -> START, counter=0.
//   START: at counter==CLKS_PER_BIT/2-1 sample; 1 -> IDLE (glitch), 0 -> DATA, counter=0.
//   DATA: sample every CLKS_PER_BIT cycles (mid-bit); shift into bit[index], LSB first.
//         After bit 7 -> STOP.
//   STOP: at mid-bit sample; 1 -> push byte, go to IDLE.
//         0 -> pulse rx_frame_err, drop byte, go to WAIT_IDLE.
//   WAIT_IDLE: stay until sync line 1 (covers break), then IDLE.
//  Push occurs on the stop-sample edge. rx_empty/rx_count update on that edge.
//   The byte is therefore visible on rx_data the following cycle.
//  Pop: rx_rd && !rx_empty advances the read pointer on the edge. The new head shows the next cycle.
//  Full push without a pop: byte dropped, rx_overflow<=1, count unchanged.
//   rx_overflow stays set until ovf_clr; if ovf_clr and a new drop coincide, the set wins.
//  Simultaneous push+pop: when full, both happen and count stays 32, no overflow.
//   When empty, the pop is ignored and the push happens, count becomes 1.
//  Pointers are FIFO_AW bits and wrap modulo 32. Count is FIFO_AW+1 bits with no wrap.
//  rx_full = (count==32); rx_empty = (count==0).
//  com_sel change while rx_busy: undefined frame; FSM must still return to IDLE within one frame.
// STRUCTURE
//  uart_pkg: FSM state localparams, default CLKS_PER_BIT, 8N1 frame constants.
//   Shared with the transmit queue.
//  Sub-module uart_sync_fifo: parameterised FWFT FIFO (push, pop, data, count, full, empty).
//   Reused for the TX queue rework.
//  The top holds the synchronizer, framer FSM, and overflow/error flags.
// TESTING (CLKS_PER_BIT=16, COM1 unless stated)
//  Send 0x55 then 0xA3 on COM1 -> rx_count=2; pop yields 0x55 then 0xA3; rx_empty=1 after the 2nd pop.
//  4-cycle low glitch on an idle line -> rx_busy pulses, no push, rx_count=0, no rx_frame_err.
//  0xC3 with stop bit low for 2 bit times -> one rx_frame_err pulse, FIFO empty.
//   FSM is in WAIT_IDLE until the line goes high; the next 0x31 is received correctly.
//  33 bytes 0x00..0x20 with no pops -> rx_full after 32 and rx_overflow=1.
//   Draining gives 0x00..0x1F in order; ovf_clr clears the flag.
//  At full, assert rx_rd on the exact push edge -> count stays 32, no overflow, order preserved.
//  Reset asserted mid-DATA of 0x7E, released with the line idle -> all outputs at reset values.
//   A subsequent 0x32 on COM2 with com_sel=1 is received; COM1 activity is ignored.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: framer states, default bit period and 8N1 frame levels.
// Used by both the receive and transmit queues.
package uart_pkg;

  localparam int unsigned DefaultClksPerBit = 16;
  localparam int unsigned DataBits          = 8;

  localparam logic IdleLevel     = 1'b1;
  localparam logic StartBitLevel = 1'b0;
  localparam logic StopBitLevel  = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } uart_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Parameterised first-word-fall-through FIFO with occupancy count.
// Push while full is accepted only when a pop happens on the same edge.
module uart_sync_fifo #(
  parameter int unsigned Width     = 8,
  parameter int unsigned AddrWidth = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [Width-1:0]     data_i,
  input  logic                 pop_i,
  output logic [Width-1:0]     data_o,
  output logic [AddrWidth:0]   count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam logic [AddrWidth:0] Depth = {1'b1, {AddrWidth{1'b0}}};

  logic [Width-1:0]     mem_q [2**AddrWidth];
  logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrWidth:0]   count_q, count_d;
  logic                 push_eff, pop_eff;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == Depth);
  assign pop_eff  = pop_i && !empty_o;
  assign push_eff = push_i && (!full_o || pop_eff);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_eff) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_eff)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_eff, pop_eff})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push_eff) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/uart_rx_queue.sv
// UART 8N1 receiver: COM port select, synchronizer, mid-bit sampling framer,
// and a FWFT byte queue toward the USB IN side with sticky overflow.
module uart_rx_queue
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
  parameter int unsigned FIFO_AW      = 5
) (
  input  logic               uart_clk,
  input  logic               uart_rst_n,
  input  logic               uart_rx_com1,
  input  logic               uart_rx_com2,
  input  logic               com_sel,
  input  logic               rx_rd,
  input  logic               ovf_clr,
  output logic [7:0]         rx_data,
  output logic               rx_empty,
  output logic               rx_full,
  output logic [FIFO_AW:0]   rx_count,
  output logic               rx_busy,
  output logic               rx_frame_err,
  output logic               rx_overflow
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullLast = CntW'(CLKS_PER_BIT - 1);

  logic        sync1_q, sync2_q, line;
  uart_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        busy_q, busy_d;
  logic        frame_err_q, frame_err_d;
  logic        ovf_q, ovf_d;
  logic        push;

  assign line = sync2_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (line == StartBitLevel) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          idx_d   = '0;
          // A start bit that is gone by mid-bit was a glitch.
          state_d = (line == StartBitLevel) ? StData : StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == FullLast) begin
          cnt_d          = '0;
          shift_d[idx_q] = line;
          if (idx_q == 3'(DataBits - 1)) state_d = StStop;
          else                           idx_d   = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == FullLast) begin
          cnt_d = '0;
          if (line == StopBitLevel) begin
            push    = 1'b1;
            state_d = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitIdle: begin
        if (line == IdleLevel) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_d = (state_d != StIdle);

  // Setting wins over clearing when a drop and ovf_clr coincide.
  always_comb begin
    ovf_d = ovf_q;
    if (push && rx_full && !rx_rd) ovf_d = 1'b1;
    else if (ovf_clr)              ovf_d = 1'b0;
  end

  always_ff @(posedge uart_clk) begin
    if (!uart_rst_n) begin
      sync1_q     <= IdleLevel;
      sync2_q     <= IdleLevel;
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      sync1_q     <= com_sel ? uart_rx_com2 : uart_rx_com1;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      ovf_q       <= ovf_d;
    end
  end

  uart_sync_fifo #(
    .Width     (8),
    .AddrWidth (FIFO_AW)
  ) u_fifo (
    .clk_i   (uart_clk),
    .rst_ni  (uart_rst_n),
    .push_i  (push),
    .data_i  (shift_q),
    .pop_i   (rx_rd),
    .data_o  (rx_data),
    .count_o (rx_count),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  assign rx_busy      = busy_q;
  assign rx_frame_err = frame_err_q;
  assign rx_overflow  = ovf_q;

endmodule

// File: tb/tb_uart_rx_queue.sv
// Directed bench for uart_rx_queue: framing, glitch, frame error, overflow,
// push/pop at full, mid-frame reset and COM2 selection.
module tb_uart_rx_queue;

  localparam int CPB = 16;

  logic       uart_clk = 1'b0;
  logic       uart_rst_n;
  logic       com1, com2, com_sel, rx_rd, ovf_clr;
  logic [7:0] rx_data;
  logic       rx_empty, rx_full, rx_busy, rx_frame_err, rx_overflow;
  logic [5:0] rx_count;

  int checks   = 0;
  int failures = 0;
  int fe_cnt   = 0;
  int busy_cnt = 0;
  int snap_fe, snap_busy;

  always #5 uart_clk = ~uart_clk;

  uart_rx_queue #(
    .CLKS_PER_BIT (CPB),
    .FIFO_AW      (5)
  ) dut (
    .uart_clk     (uart_clk),
    .uart_rst_n   (uart_rst_n),
    .uart_rx_com1 (com1),
    .uart_rx_com2 (com2),
    .com_sel      (com_sel),
    .rx_rd        (rx_rd),
    .ovf_clr      (ovf_clr),
    .rx_data      (rx_data),
    .rx_empty     (rx_empty),
    .rx_full      (rx_full),
    .rx_count     (rx_count),
    .rx_busy      (rx_busy),
    .rx_frame_err (rx_frame_err),
    .rx_overflow  (rx_overflow)
  );

  always @(posedge uart_clk) begin
    if (rx_frame_err) fe_cnt++;
    if (rx_busy)      busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves the line at v for the given number of cycles.
  task automatic drive(input logic port2, input logic v, input int cycles);
    if (port2) com2 = v;
    else       com1 = v;
    repeat (cycles) @(negedge uart_clk);
  endtask

  task automatic send_data(input logic port2, input logic [7:0] b);
    drive(port2, 1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(port2, b[i], CPB);
  endtask

  task automatic send_byte(input logic port2, input logic [7:0] b);
    send_data(port2, b);
    drive(port2, 1'b1, CPB + 4);
  endtask

  task automatic pop();
    rx_rd = 1'b1;
    @(negedge uart_clk);
    rx_rd = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_empty"}, 32'(rx_empty), 32'd1);
    check({tag, "_full"}, 32'(rx_full), 32'd0);
    check({tag, "_count"}, 32'(rx_count), 32'd0);
    check({tag, "_data"}, 32'(rx_data), 32'h00);
    check({tag, "_busy"}, 32'(rx_busy), 32'd0);
    check({tag, "_ferr"}, 32'(rx_frame_err), 32'd0);
    check({tag, "_ovf"}, 32'(rx_overflow), 32'd0);
  endtask

  initial begin
    com1 = 1'b1; com2 = 1'b1; com_sel = 1'b0;
    rx_rd = 1'b0; ovf_clr = 1'b0; uart_rst_n = 1'b0;
    repeat (3) @(negedge uart_clk);
    check_reset_state("reset");
    uart_rst_n = 1'b1;
    repeat (4) @(negedge uart_clk);

    // Two bytes, then FWFT pops.
    send_byte(1'b0, 8'h55);
    send_byte(1'b0, 8'hA3);
    check("two_count", 32'(rx_count), 32'd2);
    check("two_head0", 32'(rx_data), 32'h55);
    pop();
    check("two_head1", 32'(rx_data), 32'hA3);
    check("two_count1", 32'(rx_count), 32'd1);
    pop();
    check("two_empty", 32'(rx_empty), 32'd1);
    check("two_data0", 32'(rx_data), 32'h00);

    // Short low glitch: framer starts then aborts at mid start bit.
    snap_busy = busy_cnt;
    snap_fe   = fe_cnt;
    drive(1'b0, 1'b0, 4);
    drive(1'b0, 1'b1, 30);
    check("glitch_busy_seen", 32'(busy_cnt > snap_busy), 32'd1);
    check("glitch_busy_now", 32'(rx_busy), 32'd0);
    check("glitch_count", 32'(rx_count), 32'd0);
    check("glitch_ferr", 32'(fe_cnt - snap_fe), 32'd0);

    // 0xC3 with stop held low for two bit times.
    snap_fe = fe_cnt;
    send_data(1'b0, 8'hC3);
    drive(1'b0, 1'b0, 2 * CPB);
    check("ferr_pulses", 32'(fe_cnt - snap_fe), 32'd1);
    check("ferr_wait_busy", 32'(rx_busy), 32'd1);
    check("ferr_empty", 32'(rx_empty), 32'd1);
    drive(1'b0, 1'b1, CPB + 4);
    check("ferr_idle", 32'(rx_busy), 32'd0);
    send_byte(1'b0, 8'h31);
    check("after_ferr_count", 32'(rx_count), 32'd1);
    check("after_ferr_data", 32'(rx_data), 32'h31);
    pop();

    // Overflow: 33 bytes, no pops.
    for (int i = 0; i < 32; i++) send_byte(1'b0, 8'(i));
    check("fill_full", 32'(rx_full), 32'd1);
    check("fill_count", 32'(rx_count), 32'd32);
    check("fill_no_ovf", 32'(rx_overflow), 32'd0);
    send_byte(1'b0, 8'h20);
    check("ovf_set", 32'(rx_overflow), 32'd1);
    check("ovf_count", 32'(rx_count), 32'd32);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("drain_%0d", i), 32'(rx_data), 32'(i));
      pop();
    end
    check("drain_empty", 32'(rx_empty), 32'd1);
    check("ovf_sticky", 32'(rx_overflow), 32'd1);
    ovf_clr = 1'b1;
    @(negedge uart_clk);
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(rx_overflow), 32'd0);

    // Full, with a pop on the exact push edge (stop sample is 154 edges after the drop).
    for (int i = 0; i < 32; i++) send_byte(1'b0, 8'(8'h40 + i));
    check("full2_count", 32'(rx_count), 32'd32);
    fork
      send_byte(1'b0, 8'h60);
      begin
        repeat (154) @(posedge uart_clk);
        @(negedge uart_clk);
        rx_rd = 1'b1;
        @(negedge uart_clk);
        rx_rd = 1'b0;
      end
    join
    check("pushpop_count", 32'(rx_count), 32'd32);
    check("pushpop_no_ovf", 32'(rx_overflow), 32'd0);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("pushpop_drain_%0d", i), 32'(rx_data), 32'(8'h41 + i));
      pop();
    end
    check("pushpop_empty", 32'(rx_empty), 32'd1);

    // Reset in the middle of 0x7E's data bits, with a byte already queued.
    send_byte(1'b0, 8'h11);
    check("pre_rst_count", 32'(rx_count), 32'd1);
    drive(1'b0, 1'b0, CPB);
    drive(1'b0, 1'b0, CPB);
    drive(1'b0, 1'b1, CPB);
    com1 = 1'b1;
    uart_rst_n = 1'b0;
    repeat (3) @(negedge uart_clk);
    uart_rst_n = 1'b1;
    check_reset_state("midrst");
    repeat (20) @(negedge uart_clk);
    check("midrst_idle", 32'(rx_busy), 32'd0);

    // COM2 selected; concurrent COM1 traffic must be ignored.
    com_sel = 1'b1;
    repeat (4) @(negedge uart_clk);
    fork
      send_byte(1'b1, 8'h32);
      send_byte(1'b0, 8'h99);
    join
    check("com2_count", 32'(rx_count), 32'd1);
    check("com2_data", 32'(rx_data), 32'h32);
    pop();
    check("com2_empty", 32'(rx_empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
